hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
- Consumer-side partner to the forwarding network in the sail-core pipeline. Sits at ID.
- Tracks in-flight register producers in EX1/EX2/MEM. Stalls the ID instruction when a source register will not yet be forwardable.
- Typical cases: a 2-cycle ALU result or a load result needed by an instruction immediately behind it.
- Drives the PC/IF-ID hold (stall) and the EX1 NOP injection (bubble).

Parameters:
- DEPTH, 3: scoreboard entries (EX1, EX2, MEM); entries shifted past DEPTH-1 are discarded.
- ALU_LAT, 1: stall cycles owed by an adjacent dependent of a register-writing non-load instruction.
- LOAD_LAT, 2: stall cycles owed by an adjacent dependent of a load.
- Constraint: ALU_LAT, LOAD_LAT in 0..DEPTH.
- Countdown width CW = $clog2(DEPTH+1).

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs1  in  5  source register 1
- id_rs2  in  5  source register 2
- id_use_rs1  in  1  instruction reads rs1
- id_use_rs2  in  1  instruction reads rs2
- id_rd  in  5  destination register
- id_regwrite  in  1  instruction writes rd
- id_is_load  in  1  instruction is a load
- flush  in  1  branch/jump redirect; kills the ID and EX1 instructions
- stall  out  1  hold PC and IF/ID this cycle
- bubble  out  1  inject NOP into EX1 at next edge
- busy  out  1  some valid entry has countdown != 0
- stall_count  out  32  stall-cycle count (see Optional Feature)

Behaviour:
- Entry k (0..DEPTH-1) holds: v, rd[4:0], cnt[CW-1:0]. Entry 0 = EX1.
- Reset (async, rst_n=0): all v=0, cnt=0, stall_count=0. Outputs therefore read stall=0, bubble=0, busy=0 immediately.
- Match on rsX: id_valid & id_use_rsX & rsX!=0 & some entry has v=1 and rd==rsX.
- Youngest rule: only the lowest-index matching entry counts, because forwarding selects the youngest producer.
- hazX = match on rsX & that youngest entry's cnt!=0.
- stall = (haz1 | haz2) & !flush. bubble = stall. Both combinational, same cycle.
- Insert: ins = id_valid & id_regwrite & id_rd!=0 & !stall & !flush.
  - If ins: entry0 <= {1, id_rd, id_is_load ? LOAD_LAT : ALU_LAT}.
  - Otherwise entry0 <= invalid; this covers the bubble and flush cases.
- Shift: each edge, entry k <= entry k-1 (k>=1), with cnt decremented and saturating at 0. The shift happens unconditionally; a stall does not freeze the scoreboard.
- Flush: entry1 <= invalid instead of the shifted entry0, which kills the EX1 instruction. Entries 2+ shift normally. stall is forced 0 during flush.
- Resulting latency: a dependent immediately behind a producer stalls exactly LAT cycles. It stalls LAT-n cycles when n independent instructions sit between them (minimum 0).
- x0 is never tracked and never causes a stall.
- busy = OR over entries of (v & cnt!=0).

Optional Feature:
- Macro: HAZARD_STALL_CNT_EN.
- Defined: stall_count is a 32-bit register.
  - Increments on every edge where stall=1.
  - Wraps 0xFFFFFFFF -> 0.
  - Cleared only by reset.
- Undefined: stall_count is tied to 32'd0 and no counter flops exist.

Test Plan:
- Reset: hold rst_n=0 mid-stream with entries valid -> stall=0, busy=0, stall_count=0 asynchronously; first post-reset dependent does not stall.
- ALU hazard: ALU writes x5, next instr reads rs1=x5 -> stall=bubble=1 for exactly 1 cycle, then 0. stall_count=1 with macro.
- Load-use: load x7, next reads rs2=x7 -> stall 2 cycles. Load x7, independent, reader x7 -> stall 1 cycle. Load x7, 2 independents, reader -> 0 cycles.
- Youngest rule: load x3, then ALU x3 (separated so no stall on the ALU), then reader of x3 -> stall follows the ALU entry's countdown, not the load's.
- Flush: load x9 in ID with flush=1, next cycle reader of x9 -> stall=0 (load never inserted). Load in EX1 + flush -> entry killed, reader of x9 does not stall.
- x0/unused: producer writes x0 or reader has id_use_rs1=0 with matching rs1 -> stall=0; with macro, stall_count unchanged.

Source files
------------

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: ID-stage load-use / multi-cycle-ALU interlock for sail-core.
//
// A small scoreboard shadows the EX1/EX2/MEM producers. Each entry holds its
// destination register and a countdown that reaches zero once the result can
// be forwarded. An ID source that matches a pending producer holds PC and
// IF/ID (stall) and sends a NOP into EX1 (bubble).
//
// Optional build macro: HAZARD_STALL_CNT_EN adds a free-running 32-bit count
// of stalled cycles on stall_count. Without the macro, stall_count reads 0
// and no counter flops are built.
//
// Port names keep the pipeline-wide names used by the forwarding network.

module hazard_stall_unit #(
  parameter  int DEPTH    = 3,
  parameter  int ALU_LAT  = 1,
  parameter  int LOAD_LAT = 2,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_regwrite,
  input  logic        id_is_load,
  input  logic        flush,
  output logic        stall,
  output logic        bubble,
  output logic        busy,
  output logic [31:0] stall_count
);

  localparam logic [CW-1:0] ALU_CNT  = CW'(ALU_LAT);
  localparam logic [CW-1:0] LOAD_CNT = CW'(LOAD_LAT);

  // Scoreboard, index 0 = EX1, index DEPTH-1 = oldest tracked stage.
  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [4:0]       rd_q  [DEPTH];
  logic [4:0]       rd_d  [DEPTH];
  logic [CW-1:0]    cnt_q [DEPTH];
  logic [CW-1:0]    cnt_d [DEPTH];

  logic          hit1;
  logic          hit2;
  logic [CW-1:0] hit1_cnt;
  logic [CW-1:0] hit2_cnt;
  logic          haz1;
  logic          haz2;
  logic          ins;

  // Youngest-producer lookup: scan oldest to youngest so the lowest index
  // overwrites; forwarding always picks that entry, so only its countdown matters.
  always_comb begin
    hit1     = 1'b0;
    hit2     = 1'b0;
    hit1_cnt = '0;
    hit2_cnt = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (v_q[k] && (rd_q[k] == id_rs1)) begin
        hit1     = 1'b1;
        hit1_cnt = cnt_q[k];
      end
      if (v_q[k] && (rd_q[k] == id_rs2)) begin
        hit2     = 1'b1;
        hit2_cnt = cnt_q[k];
      end
    end
  end

  // Hazard decode; x0 is hardwired so it can never be a real dependency.
  always_comb begin
    haz1   = id_valid && id_use_rs1 && (id_rs1 != 5'd0) && hit1 && (hit1_cnt != '0);
    haz2   = id_valid && id_use_rs2 && (id_rs2 != 5'd0) && hit2 && (hit2_cnt != '0);
    stall  = (haz1 || haz2) && !flush;
    bubble = stall;
    ins    = id_valid && id_regwrite && (id_rd != 5'd0) && !stall && !flush;
  end

  // Pending-result summary, independent of what currently sits in ID.
  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (v_q[k] && (cnt_q[k] != '0)) begin
        busy = 1'b1;
      end
    end
  end

  // Next scoreboard: new producer (or hole) into EX1, everything else ages one
  // stage. The shift never freezes: a stalled ID leaves a bubble, not a hold.
  always_comb begin
    v_d[0]   = ins;
    rd_d[0]  = ins ? id_rd : 5'd0;
    cnt_d[0] = ins ? (id_is_load ? LOAD_CNT : ALU_CNT) : '0;
    for (int k = 1; k < DEPTH; k++) begin
      v_d[k]   = v_q[k-1];
      rd_d[k]  = rd_q[k-1];
      cnt_d[k] = (cnt_q[k-1] != '0) ? (cnt_q[k-1] - 1'b1) : '0;
      // A redirect squashes the instruction leaving EX1; older ones retire.
      if ((k == 1) && flush) begin
        v_d[k]   = 1'b0;
        cnt_d[k] = '0;
      end
    end
  end

  // Scoreboard registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        rd_q[k]  <= 5'd0;
        cnt_q[k] <= '0;
      end
    end else begin
      v_q <= v_d;
      for (int k = 0; k < DEPTH; k++) begin
        rd_q[k]  <= rd_d[k];
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  // Stall-cycle counter; wraps naturally at 2^32.
  always_comb begin
    stall_cnt_d = stall ? (stall_cnt_q + 32'd1) : stall_cnt_q;
  end

  // Counter register; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
`else
  assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: directed scenarios followed by random traffic.
// The reference keeps a list of issued producers stamped with their ID cycle
// and asks, for each reader, how many cycles ago the youngest matching one issued.

module tb_hazard_stall_unit;

  localparam int DEPTH    = 3;
  localparam int ALU_LAT  = 1;
  localparam int LOAD_LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic [4:0]  id_rd;
  logic        id_regwrite;
  logic        id_is_load;
  logic        flush;
  logic        stall;
  logic        bubble;
  logic        busy;
  logic [31:0] stall_count;

  hazard_stall_unit #(
    .DEPTH(DEPTH), .ALU_LAT(ALU_LAT), .LOAD_LAT(LOAD_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_is_load(id_is_load),
    .flush(flush), .stall(stall), .bubble(bubble), .busy(busy),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         t;
    logic [4:0] rd;
    int         lat;
  } prod_t;

  prod_t q[$];
  int    cyc;
  int    m_cnt;
  bit    exp_stall;
  bit    exp_busy;
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Youngest tracked producer of rs decides; it is pending while its age is
  // within its latency (age 1 = sitting in EX1).
  function automatic bit ref_haz(input logic [4:0] rs, input logic use_rs);
    int best = -1;
    int blat = 0;
    foreach (q[i]) begin
      if (q[i].rd == rs && (cyc - q[i].t) <= DEPTH && q[i].t > best) begin
        best = q[i].t;
        blat = q[i].lat;
      end
    end
    return id_valid && use_rs && (rs != 5'd0) && (best >= 0) && ((cyc - best) <= blat);
  endfunction

  task automatic model_eval();
    exp_stall = (ref_haz(id_rs1, id_use_rs1) || ref_haz(id_rs2, id_use_rs2)) && !flush;
    exp_busy  = 1'b0;
    foreach (q[i]) begin
      if ((cyc - q[i].t) <= q[i].lat && (cyc - q[i].t) <= DEPTH) exp_busy = 1'b1;
    end
  endtask

  function automatic logic [31:0] exp_count();
`ifdef HAZARD_STALL_CNT_EN
    return 32'(m_cnt);
`else
    return 32'd0;
`endif
  endfunction

  task automatic check_all();
    model_eval();
    chk("stall", {31'd0, stall}, {31'd0, exp_stall});
    chk("bubble", {31'd0, bubble}, {31'd0, exp_stall});
    chk("busy", {31'd0, busy}, {31'd0, exp_busy});
    chk("stall_count", stall_count, exp_count());
  endtask

  // Advance the reference by one ID cycle, then the DUT by one clock edge.
  task automatic tick();
    prod_t p;
    model_eval();
    if (flush) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].t == cyc - 1) q.delete(i);
      end
    end
    if (id_valid && id_regwrite && id_rd != 5'd0 && !exp_stall && !flush) begin
      p.t   = cyc;
      p.rd  = id_rd;
      p.lat = id_is_load ? LOAD_LAT : ALU_LAT;
      q.push_back(p);
    end
    if (exp_stall) m_cnt++;
    cyc++;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (cyc - q[i].t > DEPTH) q.delete(i);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                        input logic rw, input logic ld, input logic fl);
    id_valid    = v;
    id_rs1      = rs1;
    id_use_rs1  = u1;
    id_rs2      = rs2;
    id_use_rs2  = u2;
    id_rd       = rd;
    id_regwrite = rw;
    id_is_load  = ld;
    flush       = fl;
    #1;
  endtask

  // exp_st < 0 means no hand-written expectation for this cycle.
  task automatic step(input string tag, input logic v, input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                      input logic rw, input logic ld, input logic fl, input int exp_st);
    set_in(v, rs1, u1, rs2, u2, rd, rw, ld, fl);
    check_all();
    if (exp_st >= 0) chk(tag, {31'd0, stall}, 32'(exp_st));
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, -1);
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc   = 0;
    m_cnt = 0;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_bubble", {31'd0, bubble}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_count", stall_count, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ALU x5 then reader of x5: one stall cycle.
    step("alu_prod", 1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    step("alu_use0", 1, 5, 1, 0, 0, 0, 0, 0, 0, 1);
    step("alu_use1", 1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(3);

    // Load x7 then adjacent reader on rs2: two stall cycles.
    step("ld_prod", 1, 0, 0, 0, 0, 7, 1, 1, 0, 0);
    step("ld_use0", 1, 0, 0, 7, 1, 0, 0, 0, 0, 1);
    step("ld_use1", 1, 0, 0, 7, 1, 0, 0, 0, 0, 1);
    step("ld_use2", 1, 0, 0, 7, 1, 0, 0, 0, 0, 0);
    idle(3);

    // Load x7, one independent, reader: one stall cycle.
    step("ld1_prod", 1, 0, 0, 0, 0, 7, 1, 1, 0, 0);
    step("ld1_indep", 1, 1, 1, 2, 1, 11, 1, 0, 0, 0);
    step("ld1_use0", 1, 0, 0, 7, 1, 0, 0, 0, 0, 1);
    step("ld1_use1", 1, 0, 0, 7, 1, 0, 0, 0, 0, 0);
    idle(3);

    // Load x7, two independents, reader: no stall.
    step("ld2_prod", 1, 0, 0, 0, 0, 7, 1, 1, 0, 0);
    step("ld2_ind_a", 1, 0, 0, 0, 0, 12, 1, 0, 0, 0);
    step("ld2_ind_b", 1, 0, 0, 0, 0, 13, 1, 0, 0, 0);
    step("ld2_use", 1, 7, 1, 7, 1, 0, 0, 0, 0, 0);
    idle(3);

    // Load x3 shadowed by a younger ALU x3: the ALU countdown governs.
    step("yg_load", 1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
    step("yg_alu", 1, 1, 1, 0, 0, 3, 1, 0, 0, 0);
    step("yg_use0", 1, 3, 1, 0, 0, 0, 0, 0, 0, 1);
    step("yg_use1", 1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(3);

    // Flush with the load in ID: never inserted.
    step("fl_id_load", 1, 0, 0, 0, 0, 9, 1, 1, 1, 0);
    step("fl_id_use", 1, 9, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(3);

    // Flush with the load in EX1: killed, later reader does not stall.
    step("fl_ex_load", 1, 0, 0, 0, 0, 9, 1, 1, 0, 0);
    step("fl_ex_flush", 1, 9, 1, 0, 0, 0, 0, 0, 1, 0);
    step("fl_ex_use", 1, 9, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(3);

    // x0 and unused sources never stall.
    step("x0_prod", 1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    step("x0_use", 1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    step("nouse_prod", 1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
    step("nouse_use", 1, 5, 0, 5, 0, 0, 0, 0, 0, 0);
    idle(3);

    // Asynchronous reset while a load is pending.
    step("ar_load", 1, 0, 0, 0, 0, 4, 1, 1, 0, 0);
    set_in(1, 4, 1, 0, 0, 0, 0, 0, 0);
    check_all();
    chk("ar_pre_stall", {31'd0, stall}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("ar_stall", {31'd0, stall}, 32'd0);
    chk("ar_bubble", {31'd0, bubble}, 32'd0);
    chk("ar_busy", {31'd0, busy}, 32'd0);
    chk("ar_count", stall_count, 32'd0);
    q.delete();
    m_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    step("ar_post_use", 1, 4, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(3);

    // Random traffic on a small register set so matches are frequent.
    for (int n = 0; n < 500; n++) begin
      step("rand",
           1'($urandom_range(0, 3) != 0),
           5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
